mips32_datapath: RTL and testbench

Five-stage in-order 32-bit MIPS-style integer pipeline (IF, ID, EX, MEM, WB) with internal instruction ROM, data RAM and 32×32 register file. It is the top-level execution core of the RISC_MIPS_32 design. It has no forwarding or interlocks; software pads hazards with NOPs. It exposes the most recent register-file write value for observation.

---
 rtl/mips32_datapath.sv | 173 +++++++++++++++++
 tb/tb_mips32_datapath.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_datapath.sv
// mips32_datapath: five-stage in-order MIPS-style core (IF/ID/EX/MEM/WB), no forwarding or interlocks.
// Optional macro MIPS32_MUL_EN enables the MUL opcode; without it MUL behaves as a NOP.
module mips32_datapath #(
    parameter string IMEM_FILE = "program.hex",
    parameter int    MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] out,
    output logic        halted
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

`ifdef MIPS32_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    logic [31:0] r_imem [MEM_WORDS];
    logic [31:0] r_dmem [MEM_WORDS];
    logic [31:0] r_regs [32];

    logic [31:0] r_pc, r_ifid_ir, r_ifid_npc;
    logic        r_fetch_stop;
    logic [5:0]  r_idex_op;
    logic [4:0]  r_idex_dest;
    logic [31:0] r_idex_npc, r_idex_a, r_idex_b, r_idex_imm;
    logic [5:0]  r_exmem_op;
    logic [4:0]  r_exmem_dest;
    logic [31:0] r_exmem_alu, r_exmem_b;
    logic        r_memwb_hlt;
    logic [4:0]  r_memwb_dest;
    logic [31:0] r_memwb_res;
    logic [31:0] r_out;
    logic        r_halted;

    // Destination register of an instruction; 0 means "no register write".
    function automatic logic [4:0] dest_of(input logic [31:0] ir);
        logic [4:0] d;
        case (ir[31:26])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: d = ir[15:11];
            OP_MUL:                                d = MUL_EN ? ir[15:11] : 5'd0;
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW:      d = ir[20:16];
            default:                               d = 5'd0;
        endcase
        return d;
    endfunction

    logic [5:0]    w_id_op;
    logic [4:0]    w_id_rs, w_id_rt;
    logic [31:0]   w_id_a, w_id_b, w_id_imm;
    logic          w_id_hlt, w_ex_taken, w_wb_we;
    logic [31:0]   w_ex_res, w_ex_target;
    logic [AW-1:0] w_mem_addr;

    assign w_id_op  = r_ifid_ir[31:26];
    assign w_id_rs  = r_ifid_ir[25:21];
    assign w_id_rt  = r_ifid_ir[20:16];
    assign w_id_imm = {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};
    assign w_wb_we  = (r_memwb_dest != 5'd0) && !r_halted;

    // Write-through: an ID read of the register being retired this cycle sees the new value.
    assign w_id_a = (w_wb_we && r_memwb_dest == w_id_rs) ? r_memwb_res : r_regs[w_id_rs];
    assign w_id_b = (w_wb_we && r_memwb_dest == w_id_rt) ? r_memwb_res : r_regs[w_id_rt];

    assign w_ex_taken  = (r_idex_op == OP_BNEQZ && r_idex_a != 32'd0) ||
                         (r_idex_op == OP_BEQZ  && r_idex_a == 32'd0);
    assign w_ex_target = r_idex_npc + r_idex_imm;
    assign w_id_hlt    = (w_id_op == OP_HLT) && !w_ex_taken;
    assign w_mem_addr  = r_exmem_alu[AW-1:0];

    always_comb begin
        w_ex_res = 32'd0;
        case (r_idex_op)
            OP_ADD:  w_ex_res = r_idex_a + r_idex_b;
            OP_SUB:  w_ex_res = r_idex_a - r_idex_b;
            OP_AND:  w_ex_res = r_idex_a & r_idex_b;
            OP_OR:   w_ex_res = r_idex_a | r_idex_b;
            OP_SLT:  w_ex_res = {31'd0, $signed(r_idex_a) < $signed(r_idex_b)};
`ifdef MIPS32_MUL_EN
            OP_MUL:  w_ex_res = r_idex_a * r_idex_b;
`endif
            OP_ADDI, OP_LW, OP_SW: w_ex_res = r_idex_a + r_idex_imm;
            OP_SUBI: w_ex_res = r_idex_a - r_idex_imm;
            OP_SLTI: w_ex_res = {31'd0, $signed(r_idex_a) < $signed(r_idex_imm)};
            default: w_ex_res = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= '0;
            r_ifid_ir    <= '0;
            r_ifid_npc   <= '0;
            r_fetch_stop <= 1'b0;
            r_idex_op    <= '0;
            r_idex_dest  <= '0;
            r_idex_npc   <= '0;
            r_idex_a     <= '0;
            r_idex_b     <= '0;
            r_idex_imm   <= '0;
            r_exmem_op   <= '0;
            r_exmem_dest <= '0;
            r_exmem_alu  <= '0;
            r_exmem_b    <= '0;
            r_memwb_hlt  <= 1'b0;
            r_memwb_dest <= '0;
            r_memwb_res  <= '0;
            r_out        <= '0;
            r_halted     <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            // A taken branch redirects fetch and squashes the two younger slots.
            if (w_ex_taken) begin
                r_pc      <= w_ex_target;
                r_ifid_ir <= '0;
            end else if (r_fetch_stop || w_id_hlt) begin
                r_ifid_ir <= '0;
            end else begin
                r_pc       <= r_pc + 32'd1;
                r_ifid_ir  <= r_imem[r_pc[AW-1:0]];
                r_ifid_npc <= r_pc + 32'd1;
            end
            if (w_id_hlt) r_fetch_stop <= 1'b1;

            r_idex_op   <= w_ex_taken ? OP_ADD : w_id_op;
            r_idex_dest <= w_ex_taken ? 5'd0 : dest_of(r_ifid_ir);
            r_idex_npc  <= r_ifid_npc;
            r_idex_a    <= w_id_a;
            r_idex_b    <= w_id_b;
            r_idex_imm  <= w_id_imm;

            r_exmem_op   <= r_idex_op;
            r_exmem_dest <= r_idex_dest;
            r_exmem_alu  <= w_ex_res;
            r_exmem_b    <= r_idex_b;

            r_memwb_hlt  <= (r_exmem_op == OP_HLT);
            r_memwb_dest <= r_exmem_dest;
            r_memwb_res  <= (r_exmem_op == OP_LW) ? r_dmem[w_mem_addr] : r_exmem_alu;

            if (w_wb_we) begin
                r_regs[r_memwb_dest] <= r_memwb_res;
                r_out                <= r_memwb_res;
            end
            if (r_memwb_hlt) r_halted <= 1'b1;
        end
    end

    // Data RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (r_exmem_op == OP_SW && !r_halted) r_dmem[w_mem_addr] <= r_exmem_b;
    end

    assign out    = r_out;
    assign halted = r_halted;
endmodule

// File: tb/tb_mips32_datapath.sv
// Bench for mips32_datapath: programs are loaded into the ROM and compared edge by edge
// against an instruction-level reference model with a cycle-accounting rule.
`timescale 1ns/1ps
module tb_mips32_datapath;
    localparam int MW   = 256;
    localparam int MAXE = 512;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

`ifdef MIPS32_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] out_w;
    logic        halted_w;

    int          total = 0;
    int          bad = 0;
    logic [31:0] prog [MW];
    int          prog_len;
    logic [31:0] exp_q [$];
    int          halt_edge;
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [MW];

    always #5 clk = ~clk;

    mips32_datapath #(.IMEM_FILE(""), .MEM_WORDS(MW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .out    (out_w),
        .halted (halted_w)
    );

    task automatic check32(input string tag, input int e, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d got=%h exp=%h", tag, e, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input int e, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d got=%b exp=%b", tag, e, obs, exp);
        end
    endtask

    function automatic logic [31:0] rins(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, rs[4:0], rt[4:0], rd[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] iins(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic clear_prog();
        prog_len = 0;
        for (int i = 0; i < MW; i++) prog[i] = 32'd0;
    endtask

    task automatic emit(input logic [31:0] w);
        prog[prog_len] = w;
        prog_len++;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) emit(32'd0);
    endtask

    // Executes the program one instruction at a time. A non-branch occupies one fetch
    // slot, a taken branch costs two extra, and an instruction fetched on edge e retires on e+4.
    task automatic run_model();
        int pc, e, steps, dst, next_pc, next_e, addr;
        logic [31:0] ins, a, b, simm, val, cur;
        logic [5:0] op;
        logic [31:0] ev_val [MAXE];
        bit ev_on [MAXE];
        for (int i = 0; i < MAXE; i++) begin
            ev_on[i] = 1'b0;
            ev_val[i] = 32'd0;
        end
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
        halt_edge = 0;
        pc = 0;
        e = 1;
        steps = 0;
        while (halt_edge == 0 && steps < 400 && e + 4 < MAXE) begin
            ins = prog[pc % MW];
            op = ins[31:26];
            a = m_regs[ins[25:21]];
            b = m_regs[ins[20:16]];
            simm = {{16{ins[15]}}, ins[15:0]};
            addr = int'((a + simm) & 32'(MW - 1));
            dst = 0;
            val = 32'd0;
            next_pc = pc + 1;
            next_e = e + 1;
            case (op)
                OP_ADD:  begin val = a + b; dst = ins[15:11]; end
                OP_SUB:  begin val = a - b; dst = ins[15:11]; end
                OP_AND:  begin val = a & b; dst = ins[15:11]; end
                OP_OR:   begin val = a | b; dst = ins[15:11]; end
                OP_SLT:  begin val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; dst = ins[15:11]; end
                OP_MUL:  if (MUL_EN) begin val = a * b; dst = ins[15:11]; end
                OP_ADDI: begin val = a + simm; dst = ins[20:16]; end
                OP_SUBI: begin val = a - simm; dst = ins[20:16]; end
                OP_SLTI: begin val = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; dst = ins[20:16]; end
                OP_LW:   begin val = m_dmem[addr]; dst = ins[20:16]; end
                OP_SW:   m_dmem[addr] = b;
                OP_BNEQZ: if (a != 32'd0) begin next_pc = pc + 1 + int'($signed(simm)); next_e = e + 3; end
                OP_BEQZ:  if (a == 32'd0) begin next_pc = pc + 1 + int'($signed(simm)); next_e = e + 3; end
                OP_HLT:  halt_edge = e + 4;
                default: ;
            endcase
            if (dst != 0) begin
                m_regs[dst] = val;
                ev_on[e + 4] = 1'b1;
                ev_val[e + 4] = val;
            end
            pc = next_pc;
            e = next_e;
            steps++;
        end
        exp_q.delete();
        cur = 32'd0;
        for (int k = 1; k < MAXE; k++) begin
            if (ev_on[k]) cur = ev_val[k];
            exp_q.push_back(cur);
        end
    endtask

    // Resets the core, loads the ROM, then compares out/halted after every edge.
    task automatic run_prog(input string tag, input int limit);
        int n;
        logic [31:0] eo;
        rst_n = 1'b0;
        #1;
        check32({tag, "_rst_out"}, 0, out_w, 32'd0);
        check1({tag, "_rst_halted"}, 0, halted_w, 1'b0);
        for (int i = 0; i < MW; i++) dut.r_imem[i] = prog[i];
        run_model();
        n = (halt_edge != 0) ? halt_edge + 3 : 80;
        if (limit > 0 && limit < n) n = limit;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            eo = exp_q.pop_front();
            check32({tag, "_out"}, e, out_w, eo);
            check1({tag, "_halted"}, e, halted_w, (halt_edge != 0 && e >= halt_edge));
        end
    endtask

    task automatic check_regs(input string tag);
        for (int r = 1; r < 8; r++) check32({tag, "_reg"}, r, dut.r_regs[r], m_regs[r]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int sel, rd, rs, rt, ad;
        bit stored [32];
        for (int i = 0; i < MW; i++) m_dmem[i] = 32'd0;

        // ALU basics, also replayed below for the mid-run reset.
        clear_prog();
        emit(iins(OP_ADDI, 1, 0, 10));
        emit(iins(OP_ADDI, 2, 0, 20));
        nops(2);
        emit(rins(OP_ADD, 3, 1, 2));
        emit({OP_HLT, 26'd0});
        run_prog("alu", 0);
        check32("alu_final", 0, out_w, 32'd30);
        check_regs("alu");

        // SUB / SLT sign handling.
        clear_prog();
        emit(iins(OP_ADDI, 1, 0, -5));
        nops(2);
        emit(iins(OP_SLTI, 2, 1, 0));
        emit(rins(OP_SUB, 3, 0, 1));
        emit({OP_HLT, 26'd0});
        run_prog("slt", 0);
        check32("slt_final", 0, out_w, 32'd5);
        check_regs("slt");

        // Memory round trip.
        clear_prog();
        emit(iins(OP_ADDI, 1, 0, 32'h55));
        nops(2);
        emit(iins(OP_SW, 1, 0, 4));
        nops(2);
        emit(iins(OP_LW, 2, 0, 4));
        emit({OP_HLT, 26'd0});
        run_prog("mem", 0);
        check32("mem_ram4", 4, dut.r_dmem[4], 32'h55);
        check32("mem_final", 0, out_w, 32'h55);
        check_regs("mem");

        // Branch squash loop: slots after the backward BNEQZ must never write.
        clear_prog();
        emit(iins(OP_ADDI, 1, 0, 3));
        nops(2);
        emit(iins(OP_SUBI, 1, 1, 1));
        nops(2);
        emit(iins(OP_BEQZ, 0, 1, 5));
        nops(2);
        emit(iins(OP_BNEQZ, 0, 1, -7));
        emit(iins(OP_ADDI, 5, 0, 99));
        emit(iins(OP_ADDI, 5, 0, 99));
        emit({OP_HLT, 26'd0});
        run_prog("branch", 0);
        check32("branch_r5", 5, dut.r_regs[5], 32'd0);
        check32("branch_final", 0, out_w, 32'd0);
        check_regs("branch");

        // MUL, or its NOP behaviour when the multiplier is absent.
        clear_prog();
        emit(iins(OP_ADDI, 1, 0, 32'h4000));
        nops(2);
        emit(rins(OP_ADD, 1, 1, 1));
        nops(2);
        emit(rins(OP_ADD, 1, 1, 1));
        nops(2);
        emit(iins(OP_ADDI, 2, 1, 1));
        nops(2);
        emit(rins(OP_MUL, 3, 1, 2));
        emit({OP_HLT, 26'd0});
        run_prog("mul", 0);
        check32("mul_final", 0, out_w, MUL_EN ? 32'h0001_0000 : 32'h0001_0001);
        check_regs("mul");

        // Reset after 7 edges, then a full rerun of the same program.
        clear_prog();
        emit(iins(OP_ADDI, 1, 0, 10));
        emit(iins(OP_ADDI, 2, 0, 20));
        nops(2);
        emit(rins(OP_ADD, 3, 1, 2));
        emit({OP_HLT, 26'd0});
        run_prog("abort", 7);
        run_prog("rerun", 0);
        check_regs("rerun");

        // Randomized hazard-padded program.
        for (int i = 0; i < 32; i++) stored[i] = 1'b0;
        clear_prog();
        for (int r = 1; r <= 6; r++) begin
            emit(iins(OP_ADDI, r, 0, int'($urandom_range(0, 65535))));
            nops(2);
        end
        for (int i = 0; i < 18; i++) begin
            sel = int'($urandom_range(0, 10));
            rd = int'($urandom_range(0, 7));
            rs = int'($urandom_range(0, 7));
            rt = int'($urandom_range(0, 7));
            ad = int'($urandom_range(16, 31));
            case (sel)
                0: emit(rins(OP_ADD, rd, rs, rt));
                1: emit(rins(OP_SUB, rd, rs, rt));
                2: emit(rins(OP_AND, rd, rs, rt));
                3: emit(rins(OP_OR, rd, rs, rt));
                4: emit(rins(OP_SLT, rd, rs, rt));
                5: emit(rins(OP_MUL, rd, rs, rt));
                6: emit(iins(OP_ADDI, rt, rs, int'($urandom_range(0, 65535))));
                7: emit(iins(OP_SUBI, rt, rs, int'($urandom_range(0, 65535))));
                8: emit(iins(OP_SLTI, rt, rs, int'($urandom_range(0, 65535))));
                9: begin
                    emit(iins(OP_SW, rt, 0, ad));
                    stored[ad] = 1'b1;
                end
                default: begin
                    if (stored[ad]) emit(iins(OP_LW, rt, 0, ad));
                    else begin
                        emit(iins(OP_SW, rt, 0, ad));
                        stored[ad] = 1'b1;
                    end
                end
            endcase
            nops(2);
        end
        emit({OP_HLT, 26'd0});
        run_prog("rand", 0);
        check_regs("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
